// File: rtl/edge_fb_arbiter_if.sv
// Bundle of the writer, reader, RAM and status signals of edge_fb_arbiter.
// The slave modport is the arbiter side; master is the surrounding system.
interface edge_fb_arbiter_if #(
    parameter int PIXEL_BITS = 4,
    parameter int ADDR_BITS  = 17
);
    logic                  wrValid;
    logic [9:0]            wrX;
    logic [8:0]            wrY;
    logic [PIXEL_BITS-1:0] wrPixel;
    logic                  wrReady;
    logic                  rdReq;
    logic [9:0]            rdX;
    logic [8:0]            rdY;
    logic [PIXEL_BITS-1:0] rdData;
    logic                  rdDataValid;
    logic                  memEn;
    logic                  memWe;
    logic [ADDR_BITS-1:0]  memAddr;
    logic [PIXEL_BITS-1:0] memWdata;
    logic [PIXEL_BITS-1:0] memRdata;
    logic                  frameDone;
    logic                  wrOverflow;
    logic                  wrRangeErr;
    logic                  clrStatus;

    modport slave (
        input  wrValid, wrX, wrY, wrPixel, rdReq, rdX, rdY, memRdata, clrStatus,
        output wrReady, rdData, rdDataValid, memEn, memWe, memAddr, memWdata,
               frameDone, wrOverflow, wrRangeErr
    );

    modport master (
        output wrValid, wrX, wrY, wrPixel, rdReq, rdX, rdY, memRdata, clrStatus,
        input  wrReady, rdData, rdDataValid, memEn, memWe, memAddr, memWdata,
               frameDone, wrOverflow, wrRangeErr
    );
endinterface

// File: rtl/edge_fb_arbiter.sv
// Single-port frame buffer arbiter: reads have strict priority with fixed
// two-cycle latency, writes are buffered in a small FIFO and drained into idle slots.
module edge_fb_arbiter #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int PIXEL_BITS = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_BITS  = 17
) (
    input  logic                 mainClk,
    input  logic                 nreset,
    edge_fb_arbiter_if.slave     bus
);
    localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0]  DEPTH_C   = CNT_BITS'(FIFO_DEPTH);
    localparam logic [ADDR_BITS-1:0] WIDTH_A   = ADDR_BITS'(WIDTH);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH * HEIGHT - 1);
    localparam logic [31:0]          WIDTH_U   = 32'(WIDTH);
    localparam logic [31:0]          HEIGHT_U  = 32'(HEIGHT);

    typedef enum logic [1:0] {GNT_IDLE, GNT_READ, GNT_WRITE} gnt_e;

    logic [ADDR_BITS-1:0]  fifo_addr_q [FIFO_DEPTH];
    logic [PIXEL_BITS-1:0] fifo_pix_q  [FIFO_DEPTH];

    gnt_e                  gnt_q, gnt_d;
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
    logic [PIXEL_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic                  frame_done_q, frame_done_d;
    logic                  ovf_q, ovf_d, rerr_q, rerr_d;
    logic                  rd_cmd_q, rd_cmd_d, rd_cmd_inr_q, rd_cmd_inr_d;
    logic                  rd_valid_q, rd_valid_d, rd_inr_q, rd_inr_d;

    logic                  wr_in, rd_in, rd_hit, fifo_full, push, pop;
    logic [ADDR_BITS-1:0]  wr_addr, rd_addr;

    always_comb begin
        wr_in     = (32'(bus.wrX) < WIDTH_U) && (32'(bus.wrY) < HEIGHT_U);
        rd_in     = (32'(bus.rdX) < WIDTH_U) && (32'(bus.rdY) < HEIGHT_U);
        wr_addr   = ADDR_BITS'(bus.wrY) * WIDTH_A + ADDR_BITS'(bus.wrX);
        rd_addr   = ADDR_BITS'(bus.rdY) * WIDTH_A + ADDR_BITS'(bus.rdX);
        rd_hit    = bus.rdReq && rd_in;
        fifo_full = (count_q == DEPTH_C);
        // Full is judged on the pre-pop count, so a same-cycle drain never frees a slot.
        push      = bus.wrValid && wr_in && !fifo_full;
        pop       = !rd_hit && (count_q != '0);

        gnt_d       = rd_hit ? GNT_READ : (pop ? GNT_WRITE : GNT_IDLE);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (gnt_d)
            GNT_READ:  mem_addr_d = rd_addr;
            GNT_WRITE: begin
                mem_addr_d  = fifo_addr_q[rd_ptr_q];
                mem_wdata_d = fifo_pix_q[rd_ptr_q];
            end
            default: ;
        endcase
        frame_done_d = pop && (fifo_addr_q[rd_ptr_q] == LAST_ADDR);

        wr_ptr_d = wr_ptr_q + PTR_BITS'(push);
        rd_ptr_d = rd_ptr_q + PTR_BITS'(pop);
        count_d  = count_q + CNT_BITS'(push) - CNT_BITS'(pop);

        ovf_d  = (ovf_q && !bus.clrStatus) || (bus.wrValid && wr_in && fifo_full);
        rerr_d = (rerr_q && !bus.clrStatus) || (bus.wrValid && !wr_in);

        rd_cmd_d     = bus.rdReq;
        rd_cmd_inr_d = rd_hit;
        rd_valid_d   = rd_cmd_q;
        rd_inr_d     = rd_cmd_inr_q;
    end

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            gnt_q        <= GNT_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            rerr_q       <= 1'b0;
            rd_cmd_q     <= 1'b0;
            rd_cmd_inr_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_inr_q     <= 1'b0;
        end else begin
            gnt_q        <= gnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
            rerr_q       <= rerr_d;
            rd_cmd_q     <= rd_cmd_d;
            rd_cmd_inr_q <= rd_cmd_inr_d;
            rd_valid_q   <= rd_valid_d;
            rd_inr_q     <= rd_inr_d;
        end
    end

    always_ff @(posedge mainClk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_pix_q[wr_ptr_q]  <= bus.wrPixel;
        end
    end

    assign bus.memEn       = (gnt_q != GNT_IDLE);
    assign bus.memWe       = (gnt_q == GNT_WRITE);
    assign bus.memAddr     = mem_addr_q;
    assign bus.memWdata    = mem_wdata_q;
    assign bus.frameDone   = frame_done_q;
    assign bus.wrOverflow  = ovf_q;
    assign bus.wrRangeErr  = rerr_q;
    assign bus.wrReady     = (count_q < DEPTH_C);
    assign bus.rdDataValid = rd_valid_q;
    // RAM data arrives combinationally in the valid cycle; out-of-range reads return zero.
    assign bus.rdData      = rd_inr_q ? bus.memRdata : '0;
endmodule

// File: tb/tb_edge_fb_arbiter.sv
// Directed and randomized checks of edge_fb_arbiter against a queue-based
// reference model and a behavioural single-port RAM.
module tb_edge_fb_arbiter;
    localparam int W = 320, H = 240, PB = 4, DEPTH = 4, AB = 17;
    localparam int LAST = W * H - 1;

    logic mainClk = 1'b0;
    logic nreset  = 1'b0;
    always #5 mainClk = ~mainClk;

    edge_fb_arbiter_if #(.PIXEL_BITS(PB), .ADDR_BITS(AB)) bus ();

    edge_fb_arbiter #(
        .WIDTH(W), .HEIGHT(H), .PIXEL_BITS(PB), .FIFO_DEPTH(DEPTH), .ADDR_BITS(AB)
    ) dut (
        .mainClk(mainClk),
        .nreset (nreset),
        .bus    (bus)
    );

    logic          in_wv, in_rq, in_clr;
    logic [9:0]    in_wx, in_rx;
    logic [8:0]    in_wy, in_ry;
    logic [PB-1:0] in_wp;
    assign bus.wrValid   = in_wv;
    assign bus.wrX       = in_wx;
    assign bus.wrY       = in_wy;
    assign bus.wrPixel   = in_wp;
    assign bus.rdReq     = in_rq;
    assign bus.rdX       = in_rx;
    assign bus.rdY       = in_ry;
    assign bus.clrStatus = in_clr;

    logic [PB-1:0] ram [0:(1<<AB)-1];
    logic [PB-1:0] ram_rdata;
    assign bus.memRdata = ram_rdata;
    always @(posedge mainClk) begin
        if (bus.memEn) begin
            if (bus.memWe) ram[bus.memAddr] <= bus.memWdata;
            else           ram_rdata <= ram[bus.memAddr];
        end
    end

    // Reference model: expected RAM image, pending-write queue, one-deep read pipe.
    logic [PB-1:0] exp_ram [0:(1<<AB)-1];
    int            q_addr[$];
    int            q_pix[$];
    logic          s1_v;
    logic [PB-1:0] s1_d;
    logic          m_en, m_we, m_fd, m_ovf, m_rerr, m_rdy, m_rdv;
    logic [AB-1:0] m_addr;
    logic [PB-1:0] m_wdata, m_rdata;

    int passed = 0;
    int total  = 0;

    task automatic model_reset();
        q_addr.delete();
        q_pix.delete();
        s1_v = 0; s1_d = '0;
        m_en = 0; m_we = 0; m_fd = 0; m_ovf = 0; m_rerr = 0; m_rdy = 1; m_rdv = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    task automatic model_edge();
        bit rd_ok, wr_ok;
        int pre, a;
        rd_ok = (int'(in_rx) < W) && (int'(in_ry) < H);
        wr_ok = (int'(in_wx) < W) && (int'(in_wy) < H);
        pre   = q_addr.size();
        m_rdv   = s1_v;
        m_rdata = s1_d;
        s1_v    = in_rq;
        s1_d    = (in_rq && rd_ok) ? exp_ram[int'(in_ry) * W + int'(in_rx)] : '0;
        m_fd    = 0;
        if (in_rq && rd_ok) begin
            m_en = 1; m_we = 0; m_addr = AB'(int'(in_ry) * W + int'(in_rx));
        end else if (pre > 0) begin
            a = q_addr.pop_front();
            m_en = 1; m_we = 1; m_addr = AB'(a); m_wdata = PB'(q_pix.pop_front());
            exp_ram[a] = m_wdata;
            m_fd = (a == LAST);
        end else begin
            m_en = 0; m_we = 0;
        end
        if (in_clr) begin m_ovf = 0; m_rerr = 0; end
        if (in_wv) begin
            if (!wr_ok)           m_rerr = 1;
            else if (pre == DEPTH) m_ovf = 1;
            else begin
                q_addr.push_back(int'(in_wy) * W + int'(in_wx));
                q_pix.push_back(int'(in_wp));
            end
        end
        m_rdy = (q_addr.size() < DEPTH);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("memEn",       32'(bus.memEn),       32'(m_en));
        chk("memWe",       32'(bus.memWe),       32'(m_we));
        chk("memAddr",     32'(bus.memAddr),     32'(m_addr));
        chk("memWdata",    32'(bus.memWdata),    32'(m_wdata));
        chk("frameDone",   32'(bus.frameDone),   32'(m_fd));
        chk("wrOverflow",  32'(bus.wrOverflow),  32'(m_ovf));
        chk("wrRangeErr",  32'(bus.wrRangeErr),  32'(m_rerr));
        chk("wrReady",     32'(bus.wrReady),     32'(m_rdy));
        chk("rdDataValid", 32'(bus.rdDataValid), 32'(m_rdv));
        chk("rdData",      32'(bus.rdData),      32'(m_rdata));
    endtask

    task automatic step(input bit wv, input int wx, input int wy, input int wp,
                        input bit rq, input int rx, input int ry, input bit clr);
        in_wv = wv; in_wx = 10'(wx); in_wy = 9'(wy); in_wp = PB'(wp);
        in_rq = rq; in_rx = 10'(rx); in_ry = 9'(ry); in_clr = clr;
        @(posedge mainClk);
        model_edge();
        #1;
        check_all();
        @(negedge mainClk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int n_cmd, fd_cnt;
    int got [8];

    initial begin
        in_wv = 0; in_wx = '0; in_wy = '0; in_wp = '0;
        in_rq = 0; in_rx = '0; in_ry = '0; in_clr = 0;
        ram_rdata = '0;
        for (int i = 0; i < (1 << AB); i++) begin
            ram[i]     = PB'(i);
            exp_ram[i] = PB'(i);
        end
        model_reset();
        #3;
        check_all();
        chk("reset_wrReady", 32'(bus.wrReady), 32'd1);
        @(negedge mainClk);
        nreset = 1'b1;

        // Single write lands two edges after the pulse.
        step(1, 5, 2, 4'hA, 0, 0, 0, 0);
        idle();
        chk("t1_memEn", 32'(bus.memEn), 32'd1);
        chk("t1_memWe", 32'(bus.memWe), 32'd1);
        chk("t1_memAddr", 32'(bus.memAddr), 32'd645);
        chk("t1_memWdata", 32'(bus.memWdata), 32'hA);
        idle();
        chk("t1_empty", 32'(bus.wrReady), 32'd1);

        // Back-to-back reads of (0..9, 0).
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0, 0, k < 10, k, 0, 0);
            chk("t2_memWe", 32'(bus.memWe), 32'd0);
            if (k >= 1 && k <= 10) begin
                chk("t2_rdValid", 32'(bus.rdDataValid), 32'd1);
                chk("t2_rdData", 32'(bus.rdData), 32'(k - 1));
            end
        end
        chk("t2_rdValid_end", 32'(bus.rdDataValid), 32'd0);

        // Reads starve the drain; FIFO fills and two writes overflow.
        for (int i = 0; i < 6; i++) begin
            step(1, 20 + i, 3, i + 1, 1, 0, 0, 0);
            if (i == 3) chk("t3_notReady", 32'(bus.wrReady), 32'd0);
        end
        chk("t3_overflow", 32'(bus.wrOverflow), 32'd1);
        n_cmd = 0;
        for (int j = 0; j < 8; j++) begin
            idle();
            if (bus.memEn && bus.memWe) begin
                if (n_cmd < 8) got[n_cmd] = int'(bus.memAddr);
                n_cmd++;
            end
        end
        chk("t3_ncmd", 32'(n_cmd), 32'd4);
        for (int i = 0; i < 4; i++) chk("t3_order", 32'(got[i]), 32'(3 * W + 20 + i));
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t3_clr", 32'(bus.wrOverflow), 32'd0);

        // Out-of-range writes.
        step(1, 320, 0, 1, 0, 0, 0, 0);
        step(1, 0, 240, 2, 0, 0, 0, 0);
        idle();
        chk("t4_noCmd", 32'(bus.memEn), 32'd0);
        idle();
        chk("t4_rangeErr", 32'(bus.wrRangeErr), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_clr", 32'(bus.wrRangeErr), 32'd0);

        // Last pixel of the frame.
        step(1, 319, 239, 7, 0, 0, 0, 0);
        fd_cnt = 0;
        for (int j = 0; j < 4; j++) begin
            idle();
            if (bus.frameDone) begin
                fd_cnt++;
                chk("t5_addr", 32'(bus.memAddr), 32'(LAST));
                chk("t5_we", 32'(bus.memWe), 32'd1);
            end
        end
        chk("t5_pulses", 32'(fd_cnt), 32'd1);

        // Reset mid-drain discards buffered writes.
        step(1, 1, 1, 1, 0, 0, 0, 0);
        step(1, 2, 1, 2, 0, 0, 0, 0);
        step(1, 3, 1, 3, 0, 0, 0, 0);
        #2;
        nreset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_memAddr", 32'(bus.memAddr), 32'd0);
        chk("t6_wrReady", 32'(bus.wrReady), 32'd1);
        @(negedge mainClk);
        nreset = 1'b1;
        n_cmd = 0;
        for (int j = 0; j < 5; j++) begin
            idle();
            if (bus.memEn) n_cmd++;
        end
        chk("t6_noCmd", 32'(n_cmd), 32'd0);

        // Randomized traffic with varying read pressure.
        begin
            int rdpct;
            int wx, wy;
            rdpct = 50;
            for (int c = 0; c < 400; c++) begin
                if (c % 50 == 0) rdpct = int'($urandom_range(0, 100));
                wx = int'($urandom_range(0, 335));
                wy = int'($urandom_range(0, 247));
                if ($urandom_range(0, 19) == 0) begin wx = W - 1; wy = H - 1; end
                step($urandom_range(0, 1) == 1, wx, wy, int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 99)) < rdpct,
                     int'($urandom_range(0, 330)), int'($urandom_range(0, 245)),
                     $urandom_range(0, 39) == 0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/edge_fb_arbiter.md
Name: edge_fb_arbiter

Overview:
- Arbitrates a single-port edge-pixel frame buffer RAM between two requesters.
- Writer: the edge-detection pipeline behind the SPI window receiver. It issues one-cycle, non-holdable pixel write pulses with (x, y) coordinates.
- Reader: the VGA scan-out, which issues per-pixel read requests that must return with fixed latency.
- Reads have strict priority. Writes are buffered in a small FIFO and drained into idle RAM cycles. Dropped writes, range errors and frame completion are reported.

Parameters:
- WIDTH, 320, frame width in pixels.
- HEIGHT, 240, frame height in pixels.
- PIXEL_BITS, 4, stored bits per pixel.
- FIFO_DEPTH, 4, write FIFO entries; power of two, ≥2.
- ADDR_BITS, 17, RAM address width; must satisfy 2^ADDR_BITS ≥ WIDTH*HEIGHT.

Ports:
- mainClk  in  1  system clock; all logic is on its rising edge.
- nreset  in  1  asynchronous active-low reset.
- wrValid  in  1  one-cycle write pulse from the edge pipeline.
- wrX  in  10  write column.
- wrY  in  9  write row.
- wrPixel  in  PIXEL_BITS  write data.
- wrReady  out  1  high when the FIFO is not full (informational only; the writer does not wait on it).
- rdReq  in  1  VGA read request, may be asserted every cycle.
- rdX  in  10  read column.
- rdY  in  9  read row.
- rdData  out  PIXEL_BITS  read data.
- rdDataValid  out  1  rdData is valid this cycle.
- memEn  out  1  RAM access enable.
- memWe  out  1  RAM write enable (1 = write, 0 = read when memEn=1).
- memAddr  out  ADDR_BITS  RAM address.
- memWdata  out  PIXEL_BITS  RAM write data.
- memRdata  in  PIXEL_BITS  RAM read data; valid one cycle after a read command.
- frameDone  out  1  one-cycle pulse when the write to (WIDTH-1, HEIGHT-1) is committed to RAM.
- wrOverflow  out  1  sticky: a write was dropped because the FIFO was full.
- wrRangeErr  out  1  sticky: a write was dropped because it was out of range.
- clrStatus  in  1  synchronous clear of wrOverflow and wrRangeErr.

Behaviour:
- Reset (async, nreset=0):
  - FIFO is emptied.
  - memEn, memWe, memAddr, memWdata, rdDataValid, frameDone, wrOverflow and wrRangeErr are all 0.
  - rdData is 0.
  - wrReady is 1.
  - The read pipeline is flushed. Buffered writes are lost.
- Address mapping: addr = y*WIDTH + x, computed at ADDR_BITS width.
- Write acceptance (per cycle, with wrValid=1):
  - If wrX ≥ WIDTH or wrY ≥ HEIGHT: drop the write and set wrRangeErr. The range check takes precedence over the full check.
  - Else if the FIFO is full: drop the write and set wrOverflow. "Full" is evaluated on the pre-pop count, so a same-cycle pop does not make room.
  - Else: push {addr, pixel}.
- Grant register. States: GNT_IDLE, GNT_READ, GNT_WRITE. Decided each cycle from that cycle's inputs and registered onto the mem* outputs at the next edge:
  - rdReq=1 with in-range coordinates → GNT_READ: memEn=1, memWe=0, memAddr=read addr.
  - rdReq=1 with out-of-range coordinates → no RAM read. The write drain may use the slot.
  - Otherwise, FIFO not empty → GNT_WRITE: pop the head; memEn=1, memWe=1, memAddr/memWdata = head.
  - Otherwise → GNT_IDLE: memEn=0, memWe=0. memAddr/memWdata hold their previous values.
- Read latency:
  - rdReq sampled at edge N → command on the RAM pins during cycle N+1 → rdDataValid=1 during cycle N+2.
  - rdData=memRdata in that cycle for an in-range read, 0 for an out-of-range read.
  - Back-to-back rdReq yields back-to-back rdDataValid. rdData=0 whenever rdDataValid=0.
- Write starvation: continuous rdReq stalls draining indefinitely. This is by design; writes then drop via wrOverflow.
- Ordering: writes commit in acceptance order. A read of an address with a pending FIFO write returns the old RAM contents. There is no forwarding.
- frameDone asserts in the cycle the committing write command for address WIDTH*HEIGHT-1 is on the pins (memEn=memWe=1).
- clrStatus=1 clears both sticky flags. A new error event in the same cycle wins, and the flag stays set.
- wrReady = (count < FIFO_DEPTH), combinational from the registered count.
- Simultaneous push and pop with a non-full FIFO: the count is unchanged and both operations complete.

Test Plan:
1. Reset, then wrValid pulse (x=5, y=2, pix=0xA), no reads → RAM command memEn=1, memWe=1, memAddr=645, memWdata=0xA two edges after the pulse. FIFO is empty afterwards.
2. rdReq every cycle for 10 cycles at (0,0)…(9,0), with RAM preloaded addr=i → data=i[3:0] → rdDataValid high cycles N+2…N+11 with rdData 0…9. memWe never asserted.
3. rdReq held continuously while 6 write pulses arrive on consecutive cycles → first 4 buffered, then wrReady=0, writes 5–6 dropped, wrOverflow=1. After rdReq drops, exactly 4 write commands issue in order.
4. Write to (320,0), then to (0,240) → both dropped, no RAM command, wrRangeErr=1. clrStatus pulse → wrRangeErr=0.
5. Write to (319,239) with no reads → frameDone high for exactly 1 cycle, coincident with memAddr=76799, memWe=1.
6. Three writes queued, nreset pulled low mid-drain → all outputs immediately 0 (wrReady 1). After release, no further RAM commands issue.
